// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run-control front end: run FSM states,
// view-selector encodings and the statistics view index map.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    MODE_REGFILE   = 2'd0,
    MODE_DATAMEM   = 2'd1,
    MODE_STATS     = 2'd2,
    MODE_STATS_ALT = 2'd3
  } scan_mode_e;

  localparam int unsigned STAT_CYCLES     = 0;
  localparam int unsigned STAT_JUMPED     = 1;
  localparam int unsigned STAT_IS_BRANCH  = 2;
  localparam int unsigned STAT_BRANCHED   = 3;
  localparam int unsigned STAT_BUBBLE     = 4;
  localparam int unsigned STAT_LOAD_USE   = 5;
  localparam int unsigned STAT_BHT_HIT    = 6;
  localparam int unsigned STAT_BHT_FAILED = 7;
  localparam int unsigned STAT_PC         = 8;
  localparam int unsigned STAT_DISPLAY    = 9;

  localparam int unsigned NUM_STAT_VIEWS = 10;
  localparam int unsigned NUM_COUNTERS   = 8;
  localparam int unsigned STAT_IDX_W     = 4;

  // Statistics index advances 0..NUM_STAT_VIEWS-1 and wraps to 0.
  function automatic logic [STAT_IDX_W-1:0] stat_idx_next(input logic [STAT_IDX_W-1:0] idx);
    if (idx >= STAT_IDX_W'(NUM_STAT_VIEWS - 1)) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat.sv
// sat_counter: saturating up-counter.
//   clk   : clock
//   rst   : synchronous active-high reset (count -> 0)
//   inc   : increment request for this cycle
//   count : current value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: board-side run control and statistics for the pipelined core.
//   clk, rst            : clock, synchronous active-high reset
//   run_sw, step_pulse  : free-run level / single-step pulse
//   scan_mode, scan_next: view selector and index-advance pulse
//   halted..bht_failed  : per-cycle core event flags
//   pc_dbg, display, regfile_data_dbg, datamem_data_dbg : core debug data
//   cpu_en              : core enable
//   regfile_req_dbg, datamem_addr_dbg : registered debug read indices
//   view_data           : registered selected 32-bit value
//   view_index          : index of the current mode (zero-extended)
//   run_state           : run FSM state
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DM_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_sw,
  input  logic                 step_pulse,
  input  logic [1:0]           scan_mode,
  input  logic                 scan_next,
  input  logic                 halted,
  input  logic                 jumped,
  input  logic                 is_branch,
  input  logic                 branched,
  input  logic                 bubble,
  input  logic                 load_use,
  input  logic                 bht_hit,
  input  logic                 bht_failed,
  input  logic [31:0]          pc_dbg,
  input  logic [31:0]          display,
  input  logic [31:0]          regfile_data_dbg,
  input  logic [31:0]          datamem_data_dbg,
  output logic                 cpu_en,
  output logic [4:0]           regfile_req_dbg,
  output logic [DM_ADDR_W-1:0] datamem_addr_dbg,
  output logic [31:0]          view_data,
  output logic [7:0]           view_index,
  output logic [1:0]           run_state
);

  run_state_e state, state_next;
  scan_mode_e mode;

  logic [STAT_IDX_W-1:0]   stat_idx;
  logic [NUM_COUNTERS-1:0] events;
  logic [CNT_W-1:0]        cnt [NUM_COUNTERS];
  logic [31:0]             view_sel;

  assign mode = scan_mode_e'(scan_mode);

  // Run FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cpu_en <= 1'b0;
    end else begin
      state  <= state_next;
      // Registered from the next state so a STEP yields exactly one enabled cycle.
      cpu_en <= (state_next == ST_RUN) || (state_next == ST_STEP);
    end
  end

  always_comb begin
    state_next = state;
    if (halted) begin
      state_next = ST_HALTED;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (run_sw)          state_next = ST_RUN;
          else if (step_pulse) state_next = ST_STEP;
        end
        ST_RUN:    if (!run_sw) state_next = ST_IDLE;
        ST_STEP:   state_next = ST_IDLE;
        ST_HALTED: state_next = ST_HALTED;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  assign run_state = state;

  // Event counters; bit 0 is the cycle counter whose flag is always set.
  assign events = {bht_failed, bht_hit, load_use, bubble, branched, is_branch, jumped, 1'b1};

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_cnt
    sat_counter #(.WIDTH(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cpu_en & events[g]),
      .count (cnt[g])
    );
  end

  // Per-mode view indices; only the current mode's index advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      regfile_req_dbg  <= '0;
      datamem_addr_dbg <= '0;
      stat_idx         <= '0;
    end else if (scan_next) begin
      unique case (mode)
        MODE_REGFILE: regfile_req_dbg  <= regfile_req_dbg + 1'b1;
        MODE_DATAMEM: datamem_addr_dbg <= datamem_addr_dbg + 1'b1;
        default:      stat_idx         <= stat_idx_next(stat_idx);
      endcase
    end
  end

  always_comb begin
    view_sel = '0;
    unique case (mode)
      MODE_REGFILE: view_sel = regfile_data_dbg;
      MODE_DATAMEM: view_sel = datamem_data_dbg;
      default: begin
        if (stat_idx < STAT_IDX_W'(NUM_COUNTERS))      view_sel = 32'(cnt[stat_idx[2:0]]);
        else if (stat_idx == STAT_IDX_W'(STAT_PC))      view_sel = pc_dbg;
        else if (stat_idx == STAT_IDX_W'(STAT_DISPLAY)) view_sel = display;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) view_data <= '0;
    else     view_data <= view_sel;
  end

  always_comb begin
    view_index = '0;
    unique case (mode)
      MODE_REGFILE: view_index = 8'(regfile_req_dbg);
      MODE_DATAMEM: view_index = 8'(datamem_addr_dbg);
      default:      view_index = 8'(stat_idx);
    endcase
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  localparam int unsigned DMW = 4;

  logic clk = 1'b0;
  logic rst, run_sw, step_pulse, scan_next;
  logic [1:0] scan_mode;
  logic halted, jumped, is_branch, branched, bubble, load_use, bht_hit, bht_failed;
  logic [31:0] pc_dbg, display, regfile_data_dbg, datamem_data_dbg;

  logic           cpu_en, cpu_en4;
  logic [4:0]     rf_req, rf_req4;
  logic [DMW-1:0] dm_addr, dm_addr4;
  logic [31:0]    view_data, view_data4;
  logic [7:0]     view_index, view_index4;
  logic [1:0]     run_state, run_state4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural core debug memories: values derived from the address.
  function automatic logic [31:0] rf_val(input int unsigned i);
    return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
  endfunction
  function automatic logic [31:0] dm_val(input int unsigned a);
    return 32'hD000_0000 ^ (32'(a) * 32'd7);
  endfunction

  assign regfile_data_dbg = rf_val(int'(rf_req));
  assign datamem_data_dbg = dm_val(int'(dm_addr));

  cpu_run_ctrl #(.CNT_W(32), .DM_ADDR_W(DMW)) dut (
    .clk(clk), .rst(rst), .run_sw(run_sw), .step_pulse(step_pulse),
    .scan_mode(scan_mode), .scan_next(scan_next), .halted(halted), .jumped(jumped),
    .is_branch(is_branch), .branched(branched), .bubble(bubble), .load_use(load_use),
    .bht_hit(bht_hit), .bht_failed(bht_failed), .pc_dbg(pc_dbg), .display(display),
    .regfile_data_dbg(regfile_data_dbg), .datamem_data_dbg(datamem_data_dbg),
    .cpu_en(cpu_en), .regfile_req_dbg(rf_req), .datamem_addr_dbg(dm_addr),
    .view_data(view_data), .view_index(view_index), .run_state(run_state)
  );

  cpu_run_ctrl #(.CNT_W(4), .DM_ADDR_W(DMW)) dut4 (
    .clk(clk), .rst(rst), .run_sw(run_sw), .step_pulse(step_pulse),
    .scan_mode(scan_mode), .scan_next(scan_next), .halted(halted), .jumped(jumped),
    .is_branch(is_branch), .branched(branched), .bubble(bubble), .load_use(load_use),
    .bht_hit(bht_hit), .bht_failed(bht_failed), .pc_dbg(pc_dbg), .display(display),
    .regfile_data_dbg(regfile_data_dbg), .datamem_data_dbg(datamem_data_dbg),
    .cpu_en(cpu_en4), .regfile_req_dbg(rf_req4), .datamem_addr_dbg(dm_addr4),
    .view_data(view_data4), .view_index(view_index4), .run_state(run_state4)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        en;
    logic [1:0]  st;
    int unsigned rf, dm, sx;
    logic [31:0] vd, vd4;
  } exp_t;

  exp_t exp_q[$];

  int unsigned m_state = 0;   // 0 idle, 1 run, 2 single step, 3 halted
  logic        m_en = 1'b0;
  int unsigned m_rf = 0, m_dm = 0, m_sx = 0;
  longint      m_cnt [8];
  longint      m_cnt4 [8];
  logic [31:0] m_vd = '0, m_vd4 = '0;

  function automatic logic [31:0] stat_view(input longint c [8], input int unsigned idx);
    if (idx < 8)  return c[idx][31:0];
    if (idx == 8) return pc_dbg;
    return display;
  endfunction

  function automatic logic [31:0] view_of(input longint c [8]);
    if (scan_mode == 2'd0) return rf_val(m_rf);
    if (scan_mode == 2'd1) return dm_val(m_dm);
    return stat_view(c, m_sx);
  endfunction

  function automatic int unsigned next_run(input int unsigned s);
    if (halted || s == 3) return 3;
    if (s == 0) return run_sw ? 1 : (step_pulse ? 2 : 0);
    if (s == 1) return run_sw ? 1 : 0;
    return 0;
  endfunction

  task automatic model_step();
    logic [7:0] fl;
    exp_t e;
    fl = {bht_failed, bht_hit, load_use, bubble, branched, is_branch, jumped, 1'b1};
    if (rst) begin
      m_state = 0; m_en = 1'b0; m_rf = 0; m_dm = 0; m_sx = 0;
      m_vd = '0; m_vd4 = '0;
      for (int k = 0; k < 8; k++) begin m_cnt[k] = 0; m_cnt4[k] = 0; end
    end else begin
      m_vd  = view_of(m_cnt);
      m_vd4 = view_of(m_cnt4);
      if (m_en) begin
        for (int k = 0; k < 8; k++) begin
          if (fl[k]) begin
            if (m_cnt[k] < 64'hFFFF_FFFF) m_cnt[k]++;
            if (m_cnt4[k] < 15) m_cnt4[k]++;
          end
        end
      end
      if (scan_next) begin
        if (scan_mode == 2'd0)      m_rf = (m_rf + 1) % 32;
        else if (scan_mode == 2'd1) m_dm = (m_dm + 1) % (1 << DMW);
        else                        m_sx = (m_sx + 1) % 10;
      end
      m_state = next_run(m_state);
      m_en = (m_state == 1) || (m_state == 2);
    end
    e.en = m_en; e.st = 2'(m_state); e.rf = m_rf; e.dm = m_dm; e.sx = m_sx;
    e.vd = m_vd; e.vd4 = m_vd4;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- monitor ----------------
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endfunction

  initial begin
    exp_t e;
    int unsigned vi;
    forever begin
      @(negedge clk);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vi = (scan_mode == 2'd0) ? e.rf : (scan_mode == 2'd1) ? e.dm : e.sx;
        chk("cpu_en",        32'(cpu_en),     32'(e.en));
        chk("cpu_en_w4",     32'(cpu_en4),    32'(e.en));
        chk("run_state",     32'(run_state),  32'(e.st));
        chk("regfile_req",   32'(rf_req),     e.rf);
        chk("datamem_addr",  32'(dm_addr),    e.dm);
        chk("view_data",     view_data,       e.vd);
        chk("view_data_w4",  view_data4,      e.vd4);
        chk("view_index",    32'(view_index), vi);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_in();
    run_sw = 0; step_pulse = 0; scan_next = 0; halted = 0; jumped = 0;
    is_branch = 0; branched = 0; bubble = 0; load_use = 0; bht_hit = 0; bht_failed = 0;
  endtask

  task automatic do_reset();
    rst = 1; cyc(); cyc(); rst = 0;
  endtask

  initial begin
    clear_in();
    rst = 1; scan_mode = 2'd2; pc_dbg = 32'h0000_0ABC; display = 32'h1234_5678;
    #1;
    do_reset();

    // Three single steps with bubble asserted throughout.
    bubble = 1;
    for (int i = 0; i < 3; i++) begin
      step_pulse = 1; cyc(); step_pulse = 0;
      repeat (4) cyc();
    end
    bubble = 0;
    scan_next = 1; repeat (4) cyc(); scan_next = 0; cyc(); cyc(); // walk to bubble view
    do_reset();

    // Free run for 20 cycles, jumped on 4 of them.
    run_sw = 1;
    for (int i = 0; i < 20; i++) begin
      jumped = (i % 5 == 2); cyc();
    end
    run_sw = 0; jumped = 0;
    scan_next = 1; cyc(); scan_next = 0;
    repeat (3) cyc();

    // Regfile scan wraps past 31.
    scan_mode = 2'd0;
    for (int i = 0; i < 33; i++) begin scan_next = 1; cyc(); scan_next = 0; cyc(); end
    // Data-memory scan wraps past 2^DMW-1.
    scan_mode = 2'd1;
    for (int i = 0; i < 18; i++) begin scan_next = 1; cyc(); scan_next = 0; cyc(); end
    // Statistics scan, alias encoding, through 8 (pc) and 9 (display) and around.
    scan_mode = 2'd3;
    for (int i = 0; i < 18; i++) begin scan_next = 1; cyc(); scan_next = 0; cyc(); end

    // Narrow counters saturate at 15 during a 20-cycle run.
    do_reset();
    scan_mode = 2'd2;
    run_sw = 1; repeat (20) cyc(); run_sw = 0; repeat (3) cyc();

    // Halt during a run, with run_sw held and a step pulse on the same cycle.
    run_sw = 1;
    for (int i = 0; i < 12; i++) begin
      halted = (i >= 7); step_pulse = (i == 7); cyc();
    end
    halted = 0; step_pulse = 0;
    repeat (5) cyc();
    run_sw = 0; step_pulse = 1; cyc(); step_pulse = 0; cyc();
    do_reset();

    // Randomized traffic, including mid-run reset and occasional halts.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) run_sw = ~run_sw;
      step_pulse = ($urandom_range(3) == 0);
      if ($urandom_range(9) == 0) scan_mode = 2'($urandom_range(3));
      scan_next  = ($urandom_range(2) == 0);
      halted     = ($urandom_range(59) == 0);
      rst        = ($urandom_range(79) == 0);
      {jumped, is_branch, branched, bubble, load_use, bht_hit, bht_failed} = 7'($urandom);
      pc_dbg = $urandom; display = $urandom;
      cyc();
    end
    clear_in(); rst = 0;

    repeat (2) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
